// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch (F0-F2) then per-opcode execute steps (T3-T7) driving datapath strobes.
// Memory steps wait on mem_ready with an optional timeout into FAULT; halts only at instruction boundaries.
module cpu_sequencer #(
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 5,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ir,
  input  logic              con_ff,
  input  logic              mem_ready,
  input  logic              stop,
  input  logic              resume,
  output logic              gra, grb, grc,
  output logic              rin, rout, baout, cout,
  output logic              pcin, pcout, irin, marin, mdrin, mdrout,
  output logic              yin, zin, zlowout, zhighout, hiin, loin, hiout, loout,
  output logic              inportout, outportin, conin,
  output logic              mem_read, mem_write,
  output logic [ALU_W-1:0]  alu_sel,
  output logic              run,
  output logic              fault,
  output logic              retire
);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  localparam logic [3:0] ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_MUL = 4'd3,  ALU_INC = 4'd4;
  localparam logic [3:0] ALU_DIV = 4'd5,  ALU_AND = 4'd6,  ALU_OR  = 4'd7,  ALU_NEG = 4'd8;
  localparam logic [3:0] ALU_NOT = 4'd10, ALU_SHL = 4'd12, ALU_SHR = 4'd13, ALU_ROL = 4'd14;
  localparam logic [3:0] ALU_ROR = 4'd15;

  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(26);

  state_t             state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPC_W-1:0]   ir_opc;
  logic               unused_ir_bits;

  logic is_ld, is_ldi, is_st, is_ralu, is_ialu, is_muldiv, is_negnot, is_br;
  logic is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt;
  logic [3:0] op_alu;
  logic last_step, wait_step;

  assign ir_opc         = ir[DATA_W-1 -: OPC_W];
  assign unused_ir_bits = ^ir[DATA_W-OPC_W-1:0];

  // Opcode class and ALU function of the instruction latched when leaving F2.
  always_comb begin
    {is_ld, is_ldi, is_st, is_ralu, is_ialu, is_muldiv, is_negnot, is_br} = '0;
    {is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt}     = '0;
    op_alu = 4'd0;
    case (opc_q)
      OPC_W'(0):  is_ld  = 1'b1;
      OPC_W'(1):  is_ldi = 1'b1;
      OPC_W'(2):  is_st  = 1'b1;
      OPC_W'(3):  begin is_ralu = 1'b1;   op_alu = ALU_ADD; end
      OPC_W'(4):  begin is_ralu = 1'b1;   op_alu = ALU_SUB; end
      OPC_W'(5):  begin is_ralu = 1'b1;   op_alu = ALU_SHR; end
      OPC_W'(6):  begin is_ralu = 1'b1;   op_alu = ALU_SHL; end
      OPC_W'(7):  begin is_ralu = 1'b1;   op_alu = ALU_ROR; end
      OPC_W'(8):  begin is_ralu = 1'b1;   op_alu = ALU_ROL; end
      OPC_W'(9):  begin is_ralu = 1'b1;   op_alu = ALU_AND; end
      OPC_W'(10): begin is_ralu = 1'b1;   op_alu = ALU_OR;  end
      OPC_W'(11): begin is_ialu = 1'b1;   op_alu = ALU_ADD; end
      OPC_W'(12): begin is_ialu = 1'b1;   op_alu = ALU_AND; end
      OPC_W'(13): begin is_ialu = 1'b1;   op_alu = ALU_OR;  end
      OPC_W'(14): begin is_muldiv = 1'b1; op_alu = ALU_MUL; end
      OPC_W'(15): begin is_muldiv = 1'b1; op_alu = ALU_DIV; end
      OPC_W'(16): begin is_negnot = 1'b1; op_alu = ALU_NEG; end
      OPC_W'(17): begin is_negnot = 1'b1; op_alu = ALU_NOT; end
      OPC_W'(18): is_br   = 1'b1;
      OPC_W'(19): is_jr   = 1'b1;
      OPC_W'(20): is_jal  = 1'b1;
      OPC_W'(21): is_in   = 1'b1;
      OPC_W'(22): is_out  = 1'b1;
      OPC_W'(23): is_mfhi = 1'b1;
      OPC_W'(24): is_mflo = 1'b1;
      OPC_W'(25): is_nop  = 1'b1;
      OPC_W'(26): is_halt = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    last_step = ((state_q == S_T3) && (is_jr || is_in || is_out || is_mfhi || is_mflo || is_nop || is_halt))
             || ((state_q == S_T4) && (is_negnot || is_jal))
             || ((state_q == S_T5) && (is_ldi || is_ralu || is_ialu))
             || ((state_q == S_T6) && (is_muldiv || is_br))
             || ((state_q == S_T7) && (is_ld || is_st));
    wait_step = (state_q == S_F1) || ((state_q == S_T6) && is_ld) || ((state_q == S_T7) && is_st);
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = '0;
    case (state_q)
      S_RST:   state_d = stop ? S_HALT : S_F0;
      S_F0:    state_d = S_F1;
      S_F2: begin
        opc_d   = ir_opc;
        state_d = (ir_opc <= OP_HALT) ? S_T3 : S_FAULT;
      end
      S_HALT:  if (resume && !stop) state_d = S_F0;
      S_FAULT: state_d = S_FAULT;
      default: begin
        if (wait_step && !mem_ready) begin
          if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_MAX)) state_d = S_FAULT;
          else cnt_d = cnt_q + CNT_W'(1);
        end else if (last_step) begin
          state_d = (is_halt || stop) ? S_HALT : S_F0;
        end else begin
          case (state_q)
            S_F1:    state_d = S_F2;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T7;
            default: state_d = S_FAULT;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A store retires in the cycle its write completes, keeping retire a single pulse.
  assign retire = last_step && (!wait_step || mem_ready);

  always_comb begin
    {gra, grb, grc, rin, rout, baout, cout}              = '0;
    {pcin, pcout, irin, marin, mdrin, mdrout}            = '0;
    {yin, zin, zlowout, zhighout, hiin, loin, hiout, loout} = '0;
    {inportout, outportin, conin, mem_read, mem_write}   = '0;
    alu_sel = '0;
    run     = 1'b1;
    fault   = 1'b0;
    case (state_q)
      S_F0: begin pcout = 1'b1; marin = 1'b1; zin = 1'b1; alu_sel = ALU_W'(ALU_INC); end
      S_F1: begin zlowout = 1'b1; pcin = 1'b1; mdrin = 1'b1; mem_read = 1'b1; end
      S_F2: begin mdrout = 1'b1; irin = 1'b1; end
      S_T3: begin
        if (is_ld || is_ldi || is_st) begin grb = 1'b1; baout = 1'b1; yin = 1'b1; end
        if (is_ralu || is_ialu)       begin grb = 1'b1; rout = 1'b1; yin = 1'b1; end
        if (is_muldiv)                begin gra = 1'b1; rout = 1'b1; yin = 1'b1; end
        if (is_negnot) begin grb = 1'b1; rout = 1'b1; zin = 1'b1; alu_sel = ALU_W'(op_alu); end
        if (is_br)     begin gra = 1'b1; rout = 1'b1; conin = 1'b1; end
        if (is_jr)     begin gra = 1'b1; rout = 1'b1; pcin = 1'b1; end
        if (is_jal)    begin grb = 1'b1; rin = 1'b1; pcout = 1'b1; end
        if (is_in)     begin gra = 1'b1; rin = 1'b1; inportout = 1'b1; end
        if (is_out)    begin gra = 1'b1; rout = 1'b1; outportin = 1'b1; end
        if (is_mfhi)   begin gra = 1'b1; rin = 1'b1; hiout = 1'b1; end
        if (is_mflo)   begin gra = 1'b1; rin = 1'b1; loout = 1'b1; end
      end
      S_T4: begin
        if (is_ld || is_ldi || is_st) begin cout = 1'b1; zin = 1'b1; alu_sel = ALU_W'(ALU_ADD); end
        if (is_ralu)   begin grc = 1'b1; rout = 1'b1; zin = 1'b1; alu_sel = ALU_W'(op_alu); end
        if (is_ialu)   begin cout = 1'b1; zin = 1'b1; alu_sel = ALU_W'(op_alu); end
        if (is_muldiv) begin grb = 1'b1; rout = 1'b1; zin = 1'b1; alu_sel = ALU_W'(op_alu); end
        if (is_negnot) begin zlowout = 1'b1; gra = 1'b1; rin = 1'b1; end
        if (is_br)     begin pcout = 1'b1; yin = 1'b1; end
        if (is_jal)    begin gra = 1'b1; rout = 1'b1; pcin = 1'b1; end
      end
      S_T5: begin
        if (is_ld || is_st)               begin zlowout = 1'b1; marin = 1'b1; end
        if (is_ldi || is_ralu || is_ialu) begin zlowout = 1'b1; gra = 1'b1; rin = 1'b1; end
        if (is_muldiv) begin zlowout = 1'b1; loin = 1'b1; end
        if (is_br)     begin cout = 1'b1; zin = 1'b1; alu_sel = ALU_W'(ALU_ADD); end
      end
      S_T6: begin
        if (is_ld)     begin mem_read = 1'b1; mdrin = 1'b1; end
        if (is_st)     begin gra = 1'b1; rout = 1'b1; mdrin = 1'b1; end
        if (is_muldiv) begin zhighout = 1'b1; hiin = 1'b1; end
        if (is_br)     begin zlowout = 1'b1; pcin = con_ff; end
      end
      S_T7: begin
        if (is_ld) begin mdrout = 1'b1; gra = 1'b1; rin = 1'b1; end
        if (is_st) mem_write = 1'b1;
      end
      S_HALT:  run = 1'b0;
      S_FAULT: begin run = 1'b0; fault = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues per-cycle expected outputs, a monitor compares at negedge.
module tb_cpu_sequencer;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset, con_ff, mem_ready, stop, resume;
  logic [DW-1:0] ir;
  logic gra, grb, grc, rin, rout, baout, cout;
  logic pcin, pcout, irin, marin, mdrin, mdrout;
  logic yin, zin, zlowout, zhighout, hiin, loin, hiout, loout;
  logic inportout, outportin, conin, mem_read, mem_write;
  logic [3:0] alu_sel;
  logic run, fault, retire;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, cout;
    logic pcin, pcout, irin, marin, mdrin, mdrout;
    logic yin, zin, zlowout, zhighout, hiin, loin, hiout, loout;
    logic inportout, outportin, conin, mem_read, mem_write;
    logic [3:0] alu_sel;
    logic run, fault, retire;
  } outs_t;

  outs_t act;
  outs_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int errors = 0;

  assign act = {gra, grb, grc, rin, rout, baout, cout,
                pcin, pcout, irin, marin, mdrin, mdrout,
                yin, zin, zlowout, zhighout, hiin, loin, hiout, loout,
                inportout, outportin, conin, mem_read, mem_write,
                alu_sel, run, fault, retire};

  cpu_sequencer #(.DATA_W(32), .OPC_W(5), .ALU_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .stop(stop), .resume(resume),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout), .cout(cout),
    .pcin(pcin), .pcout(pcout), .irin(irin), .marin(marin), .mdrin(mdrin), .mdrout(mdrout),
    .yin(yin), .zin(zin), .zlowout(zlowout), .zhighout(zhighout), .hiin(hiin), .loin(loin),
    .hiout(hiout), .loout(loout), .inportout(inportout), .outportin(outportin), .conin(conin),
    .mem_read(mem_read), .mem_write(mem_write), .alu_sel(alu_sel),
    .run(run), .fault(fault), .retire(retire)
  );

  always #5 clk = ~clk;

  function automatic outs_t idle();
    outs_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic outs_t halted();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t faulted();
    outs_t o = '0;
    o.fault = 1'b1;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input outs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch(input logic [4:0] op, input int stalls);
    outs_t e;
    tick(); ir = {op, 27'h1234567};
    e = idle(); e.pcout = 1'b1; e.marin = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd4;
    expect_o($sformatf("op%0d F0", op), e);
    for (int i = 0; i <= stalls; i++) begin
      tick(); mem_ready = (i == stalls);
      e = idle(); e.zlowout = 1'b1; e.pcin = 1'b1; e.mdrin = 1'b1; e.mem_read = 1'b1;
      expect_o($sformatf("op%0d F1.%0d", op, i), e);
    end
    tick();
    e = idle(); e.mdrout = 1'b1; e.irin = 1'b1;
    expect_o($sformatf("op%0d F2", op), e);
  endtask

  // Effective-address steps shared by ld and st.
  task automatic addr_steps(input string nm);
    outs_t e;
    tick(); e = idle(); e.grb = 1'b1; e.baout = 1'b1; e.yin = 1'b1; expect_o({nm, " T3"}, e);
    tick(); e = idle(); e.cout = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd1; expect_o({nm, " T4"}, e);
    tick(); e = idle(); e.zlowout = 1'b1; e.marin = 1'b1; expect_o({nm, " T5"}, e);
  endtask

  task automatic br_steps(input logic cf_t6);
    outs_t e;
    fetch(5'd18, 0);
    con_ff = ~cf_t6;
    tick(); e = idle(); e.gra = 1'b1; e.rout = 1'b1; e.conin = 1'b1; expect_o("br T3", e);
    tick(); e = idle(); e.pcout = 1'b1; e.yin = 1'b1; expect_o("br T4", e);
    tick(); e = idle(); e.cout = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd1; expect_o("br T5", e);
    tick(); con_ff = cf_t6;
    e = idle(); e.zlowout = 1'b1; e.pcin = cf_t6; e.retire = 1'b1; expect_o("br T6", e);
  endtask

  // Monitor: one comparison per cycle that has a queued expectation.
  initial begin
    outs_t e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;
    reset = 1'b1; ir = '0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0; resume = 1'b0;
    tick(); expect_o("reset0", idle());
    tick(); reset = 1'b0; expect_o("reset1", idle());

    fetch(5'd3, 0);
    tick(); e = idle(); e.grb = 1'b1; e.rout = 1'b1; e.yin = 1'b1; expect_o("add T3", e);
    tick(); e = idle(); e.grc = 1'b1; e.rout = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd1; expect_o("add T4", e);
    tick(); e = idle(); e.zlowout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; e.retire = 1'b1; expect_o("add T5", e);

    fetch(5'd0, 3);
    addr_steps("ld");
    for (int i = 0; i <= 3; i++) begin
      tick(); mem_ready = (i == 3);
      e = idle(); e.mem_read = 1'b1; e.mdrin = 1'b1; expect_o($sformatf("ld T6.%0d", i), e);
    end
    tick(); e = idle(); e.mdrout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; e.retire = 1'b1; expect_o("ld T7", e);

    fetch(5'd2, 0);
    addr_steps("st");
    tick(); e = idle(); e.gra = 1'b1; e.rout = 1'b1; e.mdrin = 1'b1; expect_o("st T6", e);
    tick(); mem_ready = 1'b0; e = idle(); e.mem_write = 1'b1; expect_o("st T7 wait", e);
    tick(); mem_ready = 1'b1; e = idle(); e.mem_write = 1'b1; e.retire = 1'b1; expect_o("st T7 done", e);

    fetch(5'd20, 0);
    tick(); e = idle(); e.grb = 1'b1; e.rin = 1'b1; e.pcout = 1'b1; expect_o("jal T3", e);
    tick(); e = idle(); e.gra = 1'b1; e.rout = 1'b1; e.pcin = 1'b1; e.retire = 1'b1; expect_o("jal T4", e);

    fetch(5'd16, 0);
    tick(); e = idle(); e.grb = 1'b1; e.rout = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd8; expect_o("neg T3", e);
    tick(); e = idle(); e.zlowout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; e.retire = 1'b1; expect_o("neg T4", e);

    fetch(5'd21, 0);
    tick(); e = idle(); e.gra = 1'b1; e.rin = 1'b1; e.inportout = 1'b1; e.retire = 1'b1; expect_o("in T3", e);

    fetch(5'd25, 0);
    tick(); e = idle(); e.retire = 1'b1; expect_o("nop T3", e);

    fetch(5'd14, 0);
    tick(); e = idle(); e.gra = 1'b1; e.rout = 1'b1; e.yin = 1'b1; expect_o("mul T3", e);
    tick(); stop = 1'b1;
    e = idle(); e.grb = 1'b1; e.rout = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd3; expect_o("mul T4", e);
    tick(); e = idle(); e.zlowout = 1'b1; e.loin = 1'b1; expect_o("mul T5", e);
    tick(); e = idle(); e.zhighout = 1'b1; e.hiin = 1'b1; e.retire = 1'b1; expect_o("mul T6", e);
    tick(); resume = 1'b1; expect_o("halt stop+resume", halted());
    tick(); stop = 1'b0; expect_o("halt held", halted());
    fetch(5'd18, 0);
    resume = 1'b0;
    tick(); e = idle(); e.gra = 1'b1; e.rout = 1'b1; e.conin = 1'b1; expect_o("br0 T3", e);
    tick(); e = idle(); e.pcout = 1'b1; e.yin = 1'b1; expect_o("br0 T4", e);
    tick(); e = idle(); e.cout = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd1; expect_o("br0 T5", e);
    tick(); con_ff = 1'b0;
    e = idle(); e.zlowout = 1'b1; e.retire = 1'b1; expect_o("br0 T6 cf0", e);

    br_steps(1'b1);
    br_steps(1'b0);

    fetch(5'd26, 0);
    tick(); e = idle(); e.retire = 1'b1; expect_o("halt op T3", e);
    tick(); resume = 1'b1; expect_o("halt op HALT", halted());
    fetch(5'd18, 0);
    resume = 1'b0;
    tick(); e = idle(); e.gra = 1'b1; e.rout = 1'b1; e.conin = 1'b1; expect_o("brr T3", e);
    tick(); e = idle(); e.pcout = 1'b1; e.yin = 1'b1; expect_o("brr T4", e);
    tick(); reset = 1'b1; expect_o("async reset in T5", idle());
    tick(); reset = 1'b0; expect_o("reset hold", idle());

    fetch(5'd31, 0);
    tick(); resume = 1'b1; expect_o("illegal FAULT", faulted());
    tick(); expect_o("illegal FAULT held", faulted());
    tick(); reset = 1'b1; resume = 1'b0; expect_o("fault reset", idle());
    tick(); reset = 1'b0; expect_o("fault reset hold", idle());

    tick(); ir = {5'd25, 27'h0}; mem_ready = 1'b0;
    e = idle(); e.pcout = 1'b1; e.marin = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd4; expect_o("tmo F0", e);
    for (int i = 0; i < 5; i++) begin
      tick(); e = idle(); e.zlowout = 1'b1; e.pcin = 1'b1; e.mdrin = 1'b1; e.mem_read = 1'b1;
      expect_o($sformatf("tmo F1.%0d", i), e);
    end
    tick(); expect_o("tmo FAULT", faulted());
    tick(); mem_ready = 1'b1; expect_o("tmo FAULT held", faulted());
    tick(); reset = 1'b1; expect_o("tmo reset", idle());
    tick(); reset = 1'b0; expect_o("tmo reset hold", idle());
    tick();
    e = idle(); e.pcout = 1'b1; e.marin = 1'b1; e.zin = 1'b1; e.alu_sel = 4'd4; expect_o("recover F0", e);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
